pipe_ripple_addsub: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on input and output.
//   The WIDTH-bit carry chain is split into STAGES registered slices, so one operation is accepted per cycle.

---
 rtl/pipe_ripple_addsub.sv | 112 +++++++++++
 tb/tb_pipe_ripple_addsub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ripple_addsub.sv
// Pipelined ripple-carry adder/subtractor: the WIDTH-bit carry chain is cut into STAGES
// registered slices, with valid/ready handshakes and full backpressure on both sides.
module pipe_ripple_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam logic [STAGES-1:0] ONES = '1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic              alive_q;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  assign in_ready = alive_q & ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO   = k * SW;
    localparam int unsigned BW   = WIDTH - LO;
    localparam int unsigned ZIN  = WIDTH + BW;
    localparam int unsigned ZOUT = ZIN - SW;

    // Payload z = {b_eff bits not yet consumed, a bits not yet consumed | sum bits done}
    logic [ZIN-1:0]   z_in;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] x_d;
    logic [BW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [SW:0]      slice;
    logic [ZOUT-1:0]  z_d;
    logic [ZOUT-1:0]  z_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign z_in = {(sub ? ~b : b), a};
      assign c_in = sub ? ~cin : cin;
      assign v_in = in_valid & in_ready;
    end else begin : g_body
      assign z_in = g_stg[k-1].z_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
    end

    assign x_in  = z_in[WIDTH-1:0];
    assign b_in  = z_in[ZIN-1:WIDTH];
    assign slice = {1'b0, x_in[LO +: SW]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    always_comb begin
      x_d            = x_in;
      x_d[LO +: SW]  = slice[SW-1:0];
    end

    if (k == STAGES - 1) begin : g_tail
      logic ovf_d;
      logic ovf_q;

      assign z_d   = x_d;
      assign ovf_d = (x_in[WIDTH-1] == b_in[BW-1]) && (slice[SW-1] != x_in[WIDTH-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ovf_q <= 1'b0;
        else if (ld[k]) ovf_q <= ovf_d;
      end

      assign sum       = z_q;
      assign cout      = c_q;
      assign out_valid = v_q;
      assign ovf       = ovf_q;
    end else begin : g_mid
      assign z_d = {b_in[BW-1:SW], x_d};
    end

    // Stage loads when it or any stage downstream has a free slot, or the output drains.
    assign ld[k]  = out_ready | ~&(vld | ~(ONES << k));
    assign vld[k] = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (ld[k]) begin
        z_q <= z_d;
        c_q <= slice[SW];
        v_q <= v_in;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ripple_addsub.sv
// Self-checking bench: directed corner cases and randomized streaming for an 8/2 and a 4/4 instance.
module tb_pipe_ripple_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, ci8, sb8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, ov4, or4, ci4, sb4, co4, of4;
  logic [3:0] a4, b4, s4;

  pipe_ripple_addsub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );

  pipe_ripple_addsub #(.WIDTH(4), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int q8[$];
  int q4[$];
  int got8 = 0;
  int got4 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the unsigned and signed interpretations.
  function automatic int model(input int w, input int a, input int b, input int cin, input int sub);
    int m, half, beff, ceff, raw, sa, sb, t, ov;
    m    = 1 << w;
    half = m / 2;
    beff = (sub != 0) ? (m - 1 - b) : b;
    ceff = (sub != 0) ? (1 - cin) : cin;
    raw  = a + beff + ceff;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    t    = (sub != 0) ? (sa - sb - cin) : (sa + sb + cin);
    ov   = (t < -half || t >= half) ? 1 : 0;
    return (ov << (w + 1)) | ((raw / m) << w) | (raw % m);
  endfunction

  task automatic step8(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is, input logic ordy);
    @(negedge clk);
    iv8 = iv; a8 = ia; b8 = ib; ci8 = ic; sb8 = is; or8 = ordy;
    #1;
    if (ov8 && or8) begin
      got8++;
      if (q8.size() == 0) check("res8_unexpected", 32'(ov8), 32'(0));
      else                check("res8", 32'({of8, co8, s8}), 32'(q8.pop_front()));
    end
    if (iv8 && ir8) q8.push_back(model(8, int'(ia), int'(ib), int'(ic), int'(is)));
  endtask

  task automatic step4(input logic iv, input logic [3:0] ia, input logic [3:0] ib,
                       input logic ic, input logic is, input logic ordy, output logic acc);
    @(negedge clk);
    iv4 = iv; a4 = ia; b4 = ib; ci4 = ic; sb4 = is; or4 = ordy;
    #1;
    if (ov4 && or4) begin
      got4++;
      if (q4.size() == 0) check("res4_unexpected", 32'(ov4), 32'(0));
      else                check("res4", 32'({of4, co4, s4}), 32'(q4.pop_front()));
    end
    acc = iv4 && ir4;
    if (acc) q4.push_back(model(4, int'(ia), int'(ib), int'(ic), int'(is)));
  endtask

  task automatic dir8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic is, input logic [9:0] exp);
    step8(1'b1, ia, ib, ic, is, 1'b1);
    check({tag, "_accept"}, 32'(ir8), 32'(1));
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check({tag, "_early"}, 32'(ov8), 32'(0));
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check({tag, "_valid"}, 32'(ov8), 32'(1));
    check({tag, "_result"}, 32'({of8, co8, s8}), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] hold;
    logic       acc;
    int         idx;
    int         steps;

    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; sb8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; ci4 = 0; sb4 = 0; or4 = 1;

    // Reset state
    #12;
    check("rst_out_valid8", 32'(ov8), 32'(0));
    check("rst_outs8", 32'({of8, co8, s8}), 32'(0));
    check("rst_in_ready8", 32'(ir8), 32'(0));
    check("rst_in_ready4", 32'(ir4), 32'(0));
    check("rst_out_valid4", 32'(ov4), 32'(0));
    #10 rst_n = 1'b1;
    for (int i = 0; i < 4 && !ir8; i++) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rdy_after_rst8", 32'(ir8), 32'(1));
    check("rdy_after_rst4", 32'(ir4), 32'(1));

    // Directed arithmetic corners
    dir8("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    dir8("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    dir8("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    dir8("sub_bin",  8'h05, 8'h05, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFF});

    // Asynchronous reset with two ops in flight
    step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    iv8 = 1'b0;
    #2;
    check("rst_pre_valid", 32'(ov8), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(ov8), 32'(0));
    check("rst_async_sum", 32'({of8, co8, s8}), 32'(0));
    check("rst_async_ready", 32'(ir8), 32'(0));
    q8.delete();
    q4.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      check("rst_no_stale", 32'(ov8), 32'(0));
    end
    check("rst_ready_back", 32'(ir8), 32'(1));

    // Backpressure: only STAGES ops fit, output holds while stalled
    for (int i = 0; i < 4; i++)
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("bp_accepted", 32'(q8.size()), 32'(2));
    check("bp_in_ready", 32'(ir8), 32'(0));
    check("bp_out_valid", 32'(ov8), 32'(1));
    hold = {of8, co8, s8};
    for (int i = 0; i < 3; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check("bp_hold", 32'({ov8, of8, co8, s8}), 32'({1'b1, hold}));
    end
    got8 = 0;
    for (int i = 0; i < 4; i++) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("bp_delivered", 32'(got8), 32'(2));
    check("bp_drained", 32'(q8.size()), 32'(0));

    // Random streaming on the 8/2 instance
    for (int i = 0; i < 400; i++)
      step8(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 9) < 7));
    for (int i = 0; i < 6; i++) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rand8_drained", 32'(q8.size()), 32'(0));

    // Exhaustive {a,b,cin,sub} on the 4/4 instance with random gaps and stalls
    idx = 0;
    steps = 0;
    got4 = 0;
    while (idx < 1024 && steps < 8000) begin
      step4(1'($urandom_range(0, 3) != 0), 4'(idx >> 6), 4'(idx >> 2), 1'(idx >> 1), 1'(idx),
            1'($urandom_range(0, 3) != 0), acc);
      if (acc) idx++;
      steps++;
    end
    check("ex_all_accepted", 32'(idx), 32'(1024));
    for (int i = 0; i < 10; i++) step4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
    check("ex_all_delivered", 32'(got4), 32'(1024));
    check("ex_drained", 32'(q4.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
